// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and D-stage stall request.
// Results are computed from operands latched at issue and committed on the final busy cycle.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_sel,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             out_sel,
    input  logic             d_is_md,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [1:0]         op_sel;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, dvs, uq, ur, q, r, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    // Signed division works on magnitudes; most-negative / -1 then wraps to lo=a, hi=0.
    always_comb begin
        prod_s = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
        prod_u = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        neg_a  = ~op_sel[0] & op_a[WIDTH-1];
        neg_b  = ~op_sel[0] & op_b[WIDTH-1];
        mag_a  = neg_a ? -op_a : op_a;
        mag_b  = neg_b ? -op_b : op_b;
        dvs    = mag_b == '0 ? WIDTH'(1) : mag_b;
        uq     = mag_a / dvs;
        ur     = mag_a % dvs;
        q      = (neg_a ^ neg_b) ? -uq : uq;
        r      = neg_a ? -ur : ur;
        {res_hi, res_lo} = op_sel[1] ? (op_b == '0 ? {op_a, {WIDTH{1'b1}}} : {r, q})
                                     : (op_sel[0] ? prod_u : prod_s);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= '0;
        end else if (busy) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
                hi   <= res_hi;
                lo   <= res_lo;
                busy <= 1'b0;
            end
        end else if (!cancel) begin
            if (start) begin
                op_a   <= a;
                op_b   <= b;
                op_sel <= md_sel;
                cnt    <= md_sel[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                busy   <= 1'b1;
            end else begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end
    assign stall = d_is_md & (busy | start);
    assign out   = out_sel ? lo : hi;
endmodule
